var_latency_pipe: RTL and testbench
===================================

VAR_LATENCY_PIPE -- requirements
Module: var_latency_pipe

Interface
REQ-001 SHALL have parameter MAX_DELAY, default 8: number of physical stages and largest delay; legal range 1..64.
REQ-002 SHALL have parameter PIPE_WIDTH, default 1: data width.
REQ-003 SHALL have parameter DEFAULT_DELAY, default 5: delay in effect after reset; legal range 1..MAX_DELAY.
REQ-004 SHALL derive localparam DELAY_W = $clog2(MAX_DELAY+1).
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  one clock; reset is synchronous and active-low.
REQ-007 SHALL have port en  in  1  pipe advance enable; 0 freezes all stages.
REQ-008 SHALL have port in_valid  in  1  input beat present.
REQ-009 SHALL have port in_data  in  PIPE_WIDTH  input beat payload.
REQ-010 SHALL have port cfg_delay  in  DELAY_W  requested delay.
REQ-011 SHALL have port out_valid  out  1  output beat present.
REQ-012 SHALL have port out_data  out  PIPE_WIDTH  output beat payload.
REQ-013 SHALL have port active_delay  out  DELAY_W  delay currently in effect.
REQ-014 SHALL have port occupancy  out  DELAY_W  beats held in stages 0..active_delay-1.
REQ-015 SHALL have port drop_cnt  out  16  saturating count of dropped input beats.

Function
REQ-016 SHALL implement MAX_DELAY stages, each holding a valid bit and PIPE_WIDTH data.
REQ-017 SHALL accept a beat (accept = in_valid & en), writing it into stage 0 at the clock edge.
REQ-018 SHALL, on every edge with en=1, shift stage k into stage k+1; stage 0 takes {accept, in_data}.
REQ-019 SHALL hold all stages unchanged, valid bits and data, on every edge with en=0.
REQ-020 SHALL take out_valid as (stage[active_delay-1].valid & en) and out_data as stage[active_delay-1].data.
REQ-021 SHALL drive out_data to 0 when out_valid=0.
REQ-022 SHALL present an accepted beat on out_valid exactly active_delay enabled cycles after acceptance; cycles with en=0 do not count.
REQ-023 SHALL compute the clamped request as 1 if cfg_delay=0, MAX_DELAY if cfg_delay>MAX_DELAY, else cfg_delay.
REQ-024 SHALL update active_delay to the clamped request only on an edge where occupancy=0, accept=0, and the clamped request differs from active_delay.
REQ-025 SHALL clear the valid bits of all MAX_DELAY stages on that same edge, so no stale beats emerge.
REQ-026 SHALL otherwise defer a pending delay change indefinitely, with no loss or duplication of beats in flight.
REQ-027 SHALL update occupancy each edge as occupancy + accept - out_valid; it never exceeds active_delay.
REQ-028 SHALL increment drop_cnt by 1 on every edge with in_valid=1 and en=0, saturating at 16'hFFFF.
REQ-029 SHALL update all registers, apart from the en-gated stage hold, on every edge; drop_cnt and active_delay are not gated by en.

Reset
REQ-030 SHALL, on an edge with rst=0, clear all stage valid bits and data to 0.
REQ-031 SHALL, on that edge, set occupancy=0, drop_cnt=0 and active_delay=DEFAULT_DELAY.
REQ-032 SHALL ensure that after reset out_valid=0 and out_data=0.
REQ-033 SHALL discard beats in flight when reset is asserted mid-operation; none appear after reset release.
REQ-034 SHALL ignore in_valid and cfg_delay during reset.

Verification
REQ-035 SHALL cover: defaults, en=1, one beat 0x1 at cycle 0 -> out_valid=1 with out_data=0x1 at cycle 5 only; occupancy 1 for cycles 1..5, then 0.
REQ-036 SHALL cover: 10 back-to-back beats 0..9, delay 5 -> outputs 0..9 in order on cycles 5..14; occupancy peaks at 5.
REQ-037 SHALL cover: beat accepted, en=0 for 3 cycles mid-flight -> output at cycle 8; drop_cnt unchanged; an in_valid during en=0 -> drop_cnt=1.
REQ-038 SHALL cover: cfg_delay=2 set while 3 beats are in flight -> active_delay stays 5 until occupancy=0, then 2; the next beat emerges after 2 cycles.
REQ-039 SHALL cover clamping: cfg_delay=0 -> active_delay=1; cfg_delay=MAX_DELAY+3 -> active_delay=MAX_DELAY.
REQ-040 SHALL cover: rst=0 applied with 4 beats in flight -> out_valid stays 0 afterwards; occupancy=0; active_delay=5; drop_cnt=0.

Source files
------------

// File: rtl/var_latency_pipe.sv
// Variable-latency delay line: MAX_DELAY physical stages with a run-time
// selectable output tap. A new delay takes effect only once the pipe has
// drained, so beats already in flight keep the latency they were accepted with.
module var_latency_pipe #(
    parameter int MAX_DELAY     = 8,
    parameter int PIPE_WIDTH    = 1,
    parameter int DEFAULT_DELAY = 5,
    localparam int DELAY_W      = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [PIPE_WIDTH-1:0] in_data,
    input  logic [DELAY_W-1:0]    cfg_delay,
    output logic                  out_valid,
    output logic [PIPE_WIDTH-1:0] out_data,
    output logic [DELAY_W-1:0]    active_delay,
    output logic [DELAY_W-1:0]    occupancy,
    output logic [15:0]           drop_cnt
);

    // Requested delay forced into 1..MAX_DELAY.
    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] d);
        if (d == '0)
            return DELAY_W'(1);
        else if (d > DELAY_W'(MAX_DELAY))
            return DELAY_W'(MAX_DELAY);
        else
            return d;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] c, input logic inc);
        if (inc && (c != 16'hFFFF))
            return c + 16'd1;
        else
            return c;
    endfunction

    logic [MAX_DELAY-1:0]  vld_p;
    logic [PIPE_WIDTH-1:0] dat_p [MAX_DELAY];

    logic                  accept;
    logic [DELAY_W-1:0]    req_delay;
    logic                  reconfig;
    logic                  tap_vld;
    logic [PIPE_WIDTH-1:0] tap_dat;

    assign accept    = in_valid & en;
    assign req_delay = clamp_delay(cfg_delay);
    // Switching latency is only safe with nothing in the active stages and
    // nothing entering; otherwise the request simply waits.
    assign reconfig  = (occupancy == '0) && !accept && (req_delay != active_delay);

    // Select the stage at position active_delay-1 as the output tap.
    always_comb begin
        tap_vld = 1'b0;
        tap_dat = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (active_delay == DELAY_W'(k + 1)) begin
                tap_vld = vld_p[k];
                tap_dat = dat_p[k];
            end
        end
    end

    assign out_valid = tap_vld & en;
    assign out_data  = out_valid ? tap_dat : '0;

    // Stage valid bits, delay selection, occupancy and drop counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p        <= '0;
            active_delay <= DELAY_W'(DEFAULT_DELAY);
            occupancy    <= '0;
            drop_cnt     <= '0;
        end else begin
            // ---- stage shift (valid) ----
            if (en) begin
                vld_p[0] <= accept;
                for (int k = 1; k < MAX_DELAY; k++)
                    vld_p[k] <= vld_p[k-1];
            end
            // A latency switch flushes every stage so beats parked past the
            // old tap cannot surface at the new one.
            if (reconfig) begin
                vld_p        <= '0;
                active_delay <= req_delay;
            end
            occupancy <= occupancy + DELAY_W'(accept) - DELAY_W'(out_valid);
            drop_cnt  <= sat_inc16(drop_cnt, in_valid & ~en);
        end
    end

    // Stage payloads; shift with the valid bits, held while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < MAX_DELAY; k++)
                dat_p[k] <= '0;
        end else if (en) begin
            // ---- stage shift (data) ----
            dat_p[0] <= in_data;
            for (int k = 1; k < MAX_DELAY; k++)
                dat_p[k] <= dat_p[k-1];
        end
    end

endmodule

// File: tb/tb_var_latency_pipe.sv
// Randomised and scenario-driven bench for var_latency_pipe, compared each
// cycle against an age-tracking queue model of the delay line.
module tb_var_latency_pipe;

    localparam int MAXD    = 8;
    localparam int PW      = 8;
    localparam int DEFD    = 5;
    localparam int DELAY_W = $clog2(MAXD + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic [PW-1:0]      in_data;
    logic [DELAY_W-1:0] cfg_delay;
    logic               out_valid;
    logic [PW-1:0]      out_data;
    logic [DELAY_W-1:0] active_delay;
    logic [DELAY_W-1:0] occupancy;
    logic [15:0]        drop_cnt;

    var_latency_pipe #(
        .MAX_DELAY(MAXD), .PIPE_WIDTH(PW), .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .cfg_delay(cfg_delay), .out_valid(out_valid), .out_data(out_data),
        .active_delay(active_delay), .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: beats in flight with the number of enabled edges
    // each has seen since (and including) its acceptance edge.
    logic [PW-1:0] q_dat[$];
    int            q_age[$];
    int            m_ad;
    int            m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampd(input int c);
        if (c == 0) return 1;
        if (c > MAXD) return MAXD;
        return c;
    endfunction

    task automatic model_reset();
        q_dat.delete();
        q_age.delete();
        m_ad   = DEFD;
        m_drop = 0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance model and clock.
    task automatic step(input logic v, input logic [PW-1:0] d, input logic e, input int c);
        logic          exp_v;
        logic [PW-1:0] exp_d;
        logic          acc;
        in_valid  = v;
        in_data   = d;
        en        = e;
        cfg_delay = DELAY_W'(c);
        #2;
        exp_v = e && (q_age.size() > 0) && (q_age[0] == m_ad);
        exp_d = exp_v ? q_dat[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("out_data", 32'(out_data), 32'(exp_d));
        chk("occupancy", 32'(occupancy), 32'(q_age.size()));
        chk("active_delay", 32'(active_delay), 32'(m_ad));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        acc = v && e;
        if (!rst) begin
            model_reset();
        end else begin
            if (q_age.size() == 0 && !acc && clampd(c) != m_ad)
                m_ad = clampd(c);
            if (v && !e && m_drop != 16'hFFFF)
                m_drop++;
            if (e) begin
                if (exp_v) begin
                    void'(q_dat.pop_front());
                    void'(q_age.pop_front());
                end
                foreach (q_age[i]) q_age[i]++;
                if (acc) begin
                    q_dat.push_back(d);
                    q_age.push_back(1);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int c);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, c);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; cfg_delay = DELAY_W'(DEFD);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_active_delay", 32'(active_delay), 32'd5);

        // single beat, default delay
        step(1'b1, 8'h01, 1'b1, 5);
        idle(8, 5);

        // back-to-back burst
        for (int i = 0; i < 10; i++) step(1'b1, PW'(i), 1'b1, 5);
        idle(8, 5);

        // stall mid-flight, one dropped beat during the stall
        step(1'b1, 8'hA5, 1'b1, 5);
        idle(2, 5);
        step(1'b0, '0, 1'b0, 5);
        step(1'b1, 8'h77, 1'b0, 5);
        step(1'b0, '0, 1'b0, 5);
        idle(6, 5);
        chk("drop_after_stall", 32'(drop_cnt), 32'd1);

        // delay change requested with beats in flight
        for (int i = 0; i < 3; i++) step(1'b1, PW'(8'h30 + i), 1'b1, 2);
        chk("ad_deferred", 32'(active_delay), 32'd5);
        idle(8, 2);
        chk("ad_switched", 32'(active_delay), 32'd2);
        step(1'b1, 8'h5C, 1'b1, 2);
        idle(4, 2);

        // clamping of out-of-range requests
        idle(2, 0);
        chk("clamp_low", 32'(active_delay), 32'd1);
        idle(2, MAXD + 3);
        chk("clamp_high", 32'(active_delay), 32'(MAXD));
        idle(2, 5);

        // reset with beats in flight
        for (int i = 0; i < 4; i++) step(1'b1, PW'(8'hC0 + i), 1'b1, 5);
        rst = 1'b0;
        step(1'b1, 8'hEE, 1'b1, 3);
        rst = 1'b1;
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        chk("post_rst_ad", 32'(active_delay), 32'd5);
        chk("post_rst_drop", 32'(drop_cnt), 32'd0);
        idle(10, 5);

        // random traffic with stalls, delay changes and occasional reset
        begin
            int c = 5;
            for (int n = 0; n < 2000; n++) begin
                if ($urandom_range(0, 39) == 0) c = $urandom_range(0, MAXD + 3);
                rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                step(1'($urandom_range(0, 1)), PW'($urandom),
                     ($urandom_range(0, 4) != 0), c);
            end
            rst = 1'b1;
            for (int n = 0; n < 300; n++) begin
                if ($urandom_range(0, 9) == 0) c = $urandom_range(0, MAXD + 3);
                step(($urandom_range(0, 5) == 0), PW'($urandom), 1'b1, c);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
